// File: rtl/mem_wb_stage.sv
// mem_wb_stage: RV32I memory-access and writeback stage.
// Drives a req/gnt/rvalid data-memory port that may insert wait states, does sub-word
// stores and loads, stalls upstream (m_ready=0) while an access is outstanding, and
// registers every W-stage output.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned SH/SW instead of issuing them.
module mem_wb_stage #(
  parameter int unsigned DPW     = 32,
  parameter int unsigned ADW     = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m_valid,
  output logic               m_ready,
  input  logic               flush,
  input  logic               regwriteM,
  input  logic               resultsrcM,
  input  logic               memwriteM,
  input  logic               memreadM,
  input  logic [2:0]         funct3M,
  input  logic [DPW-1:0]     aluresultM,
  input  logic [DPW-1:0]     Rd2M,
  input  logic [ADW-1:0]     RdM,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DPW/8-1:0]   dmem_be,
  output logic [DPW-1:0]     dmem_addr,
  output logic [DPW-1:0]     dmem_wdata,
  input  logic               dmem_gnt,
  input  logic               dmem_rvalid,
  input  logic [DPW-1:0]     dmem_rdata,
  output logic               w_valid,
  output logic               regwriteW,
  output logic               resultsrcW,
  output logic [DPW-1:0]     aluresultW,
  output logic [DPW-1:0]     ReadDataW,
  output logic [ADW-1:0]     RdW,
  output logic               bus_errW,
  output logic               misalignW
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TmoLast = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e           state_q, state_d;
  logic             regwrite_q, resultsrc_q, memwrite_q, kill_q, kill_d;
  logic [2:0]       funct3_q;
  logic [DPW-1:0]   addr_q, data_q;
  logic [ADW-1:0]   rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Per-cycle decisions
  logic             hold_ld, done, retire, ret_load, ret_err, ret_mis, req, mis, mem_op, tmo;
  logic             kill_eff;

  // Fields seen by the memory port and the W registers: live inputs in IDLE, hold regs after
  logic             sel_we, sel_regwrite, sel_resultsrc;
  logic [2:0]       sel_f3;
  logic [DPW-1:0]   sel_addr, sel_data;
  logic [ADW-1:0]   sel_rd;
  logic [DPW/8-1:0] st_be;
  logic [DPW-1:0]   st_wdata, ld_val;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  assign mem_op = memreadM | memwriteM;

`ifdef MISALIGN_TRAP_EN
  assign mis = memwriteM & (((funct3M[1:0] == 2'b01) & aluresultM[0]) |
                            ((funct3M[1:0] == 2'b10) & (aluresultM[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  // Source mux for the access fields
  always_comb begin
    if (state_q == StIdle) begin
      sel_we        = memwriteM;
      sel_regwrite  = regwriteM;
      sel_resultsrc = resultsrcM;
      sel_f3        = funct3M;
      sel_addr      = aluresultM;
      sel_data      = Rd2M;
      sel_rd        = RdM;
    end else begin
      sel_we        = memwrite_q;
      sel_regwrite  = regwrite_q;
      sel_resultsrc = resultsrc_q;
      sel_f3        = funct3_q;
      sel_addr      = addr_q;
      sel_data      = data_q;
      sel_rd        = rd_q;
    end
  end

  // Store lane placement
  always_comb begin
    st_be    = '1;
    st_wdata = sel_data;
    case (sel_f3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << sel_addr[1:0];
        st_wdata = {4{sel_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {sel_addr[1], 1'b0};
        st_wdata = {2{sel_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension from the latched address
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'b0, ld_byte};
      3'b101:  ld_val = {16'b0, ld_half};
      default: ld_val = dmem_rdata;
    endcase
  end

  assign tmo      = (TIMEOUT != 0) && (cnt_q == TmoLast);
  assign kill_eff = kill_q | flush;

  // Next-state, request and retire decisions
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kill_d   = kill_q;
    hold_ld  = 1'b0;
    done     = 1'b0;
    ret_load = 1'b0;
    ret_err  = 1'b0;
    ret_mis  = 1'b0;
    req      = 1'b0;
    unique case (state_q)
      StIdle: begin
        req = m_valid & mem_op & ~flush & ~mis;
        if (m_valid && !flush) begin
          hold_ld = 1'b1;
          cnt_d   = '0;
          kill_d  = 1'b0;
          if (!mem_op || mis) begin
            done    = 1'b1;
            ret_mis = mis;
          end else if (memwriteM) begin
            if (dmem_gnt) done = 1'b1;
            else          state_d = StReq;
          end else begin
            state_d = dmem_gnt ? StResp : StReq;
          end
        end
      end
      StReq: begin
        req    = 1'b1;
        kill_d = kill_eff;
        if (dmem_gnt) begin
          cnt_d = '0;
          if (memwrite_q) begin
            done    = 1'b1;
            state_d = StIdle;
          end else if (dmem_rvalid) begin
            done     = 1'b1;
            ret_load = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StResp;
          end
        end else if (tmo) begin
          done    = 1'b1;
          ret_err = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        kill_d = kill_eff;
        if (dmem_rvalid) begin
          done     = 1'b1;
          ret_load = 1'b1;
          state_d  = StIdle;
        end else if (tmo) begin
          done    = 1'b1;
          ret_err = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Flushed in-flight accesses finish on the bus but never reach W
    retire = done & ~((state_q != StIdle) & kill_eff);
  end

  assign m_ready    = (state_q == StIdle);
  assign dmem_req   = req;
  assign dmem_we    = req & sel_we;
  assign dmem_be    = req ? st_be : '0;
  assign dmem_addr  = req ? {sel_addr[DPW-1:2], 2'b00} : '0;
  assign dmem_wdata = req ? st_wdata : '0;

  // FSM, timeout counter and hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      regwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      memwrite_q  <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_q        <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      if (hold_ld) begin
        regwrite_q  <= regwriteM;
        resultsrc_q <= resultsrcM;
        memwrite_q  <= memwriteM;
        funct3_q    <= funct3M;
        addr_q      <= aluresultM;
        data_q      <= Rd2M;
        rd_q        <= RdM;
      end
    end
  end

  // W-stage registers, updated only on retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid    <= 1'b0;
      regwriteW  <= 1'b0;
      resultsrcW <= 1'b0;
      aluresultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      bus_errW   <= 1'b0;
      misalignW  <= 1'b0;
    end else begin
      w_valid <= retire;
      if (retire) begin
        regwriteW  <= sel_regwrite & ~ret_err & ~ret_mis;
        resultsrcW <= sel_resultsrc;
        aluresultW <= sel_addr;
        RdW        <= sel_rd;
        bus_errW   <= ret_err;
        misalignW  <= ret_mis;
        if (ret_load) ReadDataW <= ld_val;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (TIMEOUT=4 so the bus-error path is reachable quickly).
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_valid, m_ready, flush;
  logic        regwriteM, resultsrcM, memwriteM, memreadM;
  logic [2:0]  funct3M;
  logic [31:0] aluresultM, Rd2M;
  logic [4:0]  RdM;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        w_valid, regwriteW, resultsrcW, bus_errW, misalignW;
  logic [31:0] aluresultW, ReadDataW;
  logic [4:0]  RdW;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DPW(32), .ADW(5), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_ready(m_ready), .flush(flush),
    .regwriteM(regwriteM), .resultsrcM(resultsrcM), .memwriteM(memwriteM),
    .memreadM(memreadM), .funct3M(funct3M), .aluresultM(aluresultM), .Rd2M(Rd2M),
    .RdM(RdM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .w_valid(w_valid),
    .regwriteW(regwriteW), .resultsrcW(resultsrcW), .aluresultW(aluresultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .bus_errW(bus_errW), .misalignW(misalignW)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    m_valid = 0; flush = 0; regwriteM = 0; resultsrcM = 0; memwriteM = 0; memreadM = 0;
    funct3M = 0; aluresultM = 0; Rd2M = 0; RdM = 0; dmem_gnt = 0; dmem_rvalid = 0;
    dmem_rdata = 0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (m_ready !== 1'b1) $display("FAIL rst_m_ready got %0h want 1", m_ready); else passed++;
    total++; if (dmem_req !== 1'b0) $display("FAIL rst_req got %0h want 0", dmem_req); else passed++;
    total++; if (w_valid !== 1'b0) $display("FAIL rst_w_valid got %0h want 0", w_valid); else passed++;
    total++; if ({aluresultW, ReadDataW} !== 64'h0) $display("FAIL rst_wdata got %h want 0", {aluresultW, ReadDataW}); else passed++;
    total++; if ({regwriteW, resultsrcW, bus_errW, misalignW, RdW} !== 9'h0) $display("FAIL rst_wctl got %h want 0", {regwriteW, resultsrcW, bus_errW, misalignW, RdW}); else passed++;
    @(negedge clk) rst_n = 1;
    step();
  endtask

  task automatic test_store_byte();
    clr(); m_valid = 1; memwriteM = 1; funct3M = 3'b000; aluresultM = 32'h1003;
    Rd2M = 32'h0000_00A5; dmem_gnt = 1;
    #1;
    total++; if (dmem_req !== 1'b1) $display("FAIL sb_req got %0h want 1", dmem_req); else passed++;
    total++; if (dmem_we !== 1'b1) $display("FAIL sb_we got %0h want 1", dmem_we); else passed++;
    total++; if (dmem_be !== 4'b1000) $display("FAIL sb_be got %b want 1000", dmem_be); else passed++;
    total++; if (dmem_wdata !== 32'hA5A5A5A5) $display("FAIL sb_wdata got %h want a5a5a5a5", dmem_wdata); else passed++;
    total++; if (dmem_addr !== 32'h1000) $display("FAIL sb_addr got %h want 00001000", dmem_addr); else passed++;
    step(); clr();
    total++; if (w_valid !== 1'b1) $display("FAIL sb_w_valid got %0h want 1", w_valid); else passed++;
    total++; if (m_ready !== 1'b1) $display("FAIL sb_m_ready got %0h want 1", m_ready); else passed++;
    step();
    total++; if (w_valid !== 1'b0) $display("FAIL sb_w_pulse got %0h want 0", w_valid); else passed++;
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] ad [6] = '{32'h2002, 32'h2002, 32'h2002, 32'h2000, 32'h2004, 32'h2001};
    logic [31:0] rd [6] = '{32'h00800000, 32'h00800000, 32'h80010000, 32'h80017FFE,
                            32'h89ABCDEF, 32'h00007F00};
    logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00007FFE,
                            32'h89ABCDEF, 32'h0000007F};
    for (int i = 0; i < 6; i++) begin
      clr(); m_valid = 1; memreadM = 1; regwriteM = 1; resultsrcM = 1; RdM = 5;
      funct3M = f3[i]; aluresultM = ad[i]; dmem_gnt = 1;
      #1;
      total++; if (dmem_addr !== {ad[i][31:2], 2'b00}) $display("FAIL ld%0d_addr got %h want %h", i, dmem_addr, {ad[i][31:2], 2'b00}); else passed++;
      step(); clr();
      total++; if (m_ready !== 1'b0) $display("FAIL ld%0d_m_ready got %0h want 0", i, m_ready); else passed++;
      dmem_rvalid = 1; dmem_rdata = rd[i];
      step(); dmem_rvalid = 0;
      total++; if (w_valid !== 1'b1) $display("FAIL ld%0d_w_valid got %0h want 1", i, w_valid); else passed++;
      total++; if (ReadDataW !== ex[i]) $display("FAIL ld%0d_data got %h want %h", i, ReadDataW, ex[i]); else passed++;
    end
    total++; if ({regwriteW, resultsrcW, RdW} !== {1'b1, 1'b1, 5'd5}) $display("FAIL ld_wctl got %h want %h", {regwriteW, resultsrcW, RdW}, {1'b1, 1'b1, 5'd5}); else passed++;
  endtask

  task automatic test_load_wait();
    clr(); m_valid = 1; memreadM = 1; regwriteM = 1; funct3M = 3'b010; aluresultM = 32'h4008;
    RdM = 7;
    #1;
    total++; if ({dmem_req, dmem_we, dmem_be} !== 6'b1_0_1111) $display("FAIL lw_req got %b want 101111", {dmem_req, dmem_we, dmem_be}); else passed++;
    step();
    // Scramble the M inputs: the request must come from the hold registers now
    clr(); aluresultM = 32'hDEADBEEF; funct3M = 3'b000;
    for (int i = 0; i < 3; i++) begin
      total++; if ({m_ready, w_valid, dmem_req} !== 3'b001) $display("FAIL lw_req_wait%0d got %b want 001", i, {m_ready, w_valid, dmem_req}); else passed++;
      total++; if ({dmem_addr, dmem_be} !== {32'h4008, 4'b1111}) $display("FAIL lw_stable%0d got %h want 40081111", i, {dmem_addr, dmem_be}); else passed++;
      if (i == 2) dmem_gnt = 1;
      step();
    end
    dmem_gnt = 0;
    for (int i = 0; i < 2; i++) begin
      total++; if ({m_ready, w_valid, dmem_req} !== 3'b000) $display("FAIL lw_resp_wait%0d got %b want 000", i, {m_ready, w_valid, dmem_req}); else passed++;
      step();
    end
    dmem_rvalid = 1; dmem_rdata = 32'h12345678;
    step(); dmem_rvalid = 0;
    total++; if ({w_valid, ReadDataW, RdW} !== {1'b1, 32'h12345678, 5'd7}) $display("FAIL lw_retire got %h want %h", {w_valid, ReadDataW, RdW}, {1'b1, 32'h12345678, 5'd7}); else passed++;
    step();
    total++; if ({w_valid, m_ready} !== 2'b01) $display("FAIL lw_after got %b want 01", {w_valid, m_ready}); else passed++;
  endtask

  task automatic test_store_half_wait();
    clr(); m_valid = 1; memwriteM = 1; funct3M = 3'b001; aluresultM = 32'h1006;
    Rd2M = 32'h1234BEEF;
    #1;
    total++; if ({dmem_be, dmem_wdata} !== {4'b1100, 32'hBEEFBEEF}) $display("FAIL sh_lane got %h want cbeefbeef", {dmem_be, dmem_wdata}); else passed++;
    step(); clr();
    total++; if ({m_ready, dmem_req, dmem_addr, dmem_be} !== {2'b01, 32'h1004, 4'b1100}) $display("FAIL sh_held got %h want %h", {m_ready, dmem_req, dmem_addr, dmem_be}, {2'b01, 32'h1004, 4'b1100}); else passed++;
    dmem_gnt = 1;
    step(); clr();
    total++; if ({w_valid, aluresultW} !== {1'b1, 32'h1006}) $display("FAIL sh_retire got %h want 100001006", {w_valid, aluresultW}); else passed++;
  endtask

  task automatic test_non_mem();
    clr(); m_valid = 1; regwriteM = 1; aluresultM = 32'h11223344; RdM = 9;
    #1;
    total++; if (dmem_req !== 1'b0) $display("FAIL alu_req got %0h want 0", dmem_req); else passed++;
    step(); clr();
    total++; if ({w_valid, regwriteW, bus_errW, RdW, aluresultW} !== {3'b110, 5'd9, 32'h11223344}) $display("FAIL alu_retire got %h want %h", {w_valid, regwriteW, bus_errW, RdW, aluresultW}, {3'b110, 5'd9, 32'h11223344}); else passed++;
    // Flush in IDLE drops the instruction and never reaches the bus
    m_valid = 1; memwriteM = 1; flush = 1; RdM = 3; dmem_gnt = 1;
    #1;
    total++; if (dmem_req !== 1'b0) $display("FAIL flush_idle_req got %0h want 0", dmem_req); else passed++;
    step(); clr();
    total++; if ({w_valid, RdW} !== {1'b0, 5'd9}) $display("FAIL flush_idle_w got %h want 09", {w_valid, RdW}); else passed++;
  endtask

  task automatic test_flush_resp();
    clr(); m_valid = 1; memreadM = 1; regwriteM = 1; funct3M = 3'b010; aluresultM = 32'h60;
    RdM = 12; dmem_gnt = 1;
    step(); clr();
    flush = 1;
    step(); flush = 0;
    dmem_rvalid = 1; dmem_rdata = 32'h77;
    step(); dmem_rvalid = 0;
    total++; if ({w_valid, m_ready} !== 2'b01) $display("FAIL flush_resp got %b want 01", {w_valid, m_ready}); else passed++;
    total++; if ({RdW, ReadDataW} !== {5'd9, 32'h12345678}) $display("FAIL flush_resp_w got %h want %h", {RdW, ReadDataW}, {5'd9, 32'h12345678}); else passed++;
  endtask

  task automatic test_timeout();
    clr(); m_valid = 1; memreadM = 1; regwriteM = 1; funct3M = 3'b010; aluresultM = 32'h50;
    RdM = 3;
    step(); clr();
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({m_ready, w_valid} !== 2'b00) $display("FAIL tmo_wait%0d got %b want 00", i, {m_ready, w_valid}); else passed++;
    end
    step();
    total++; if ({w_valid, bus_errW, regwriteW, m_ready} !== 4'b1101) $display("FAIL tmo_retire got %b want 1101", {w_valid, bus_errW, regwriteW, m_ready}); else passed++;
    total++; if (dmem_req !== 1'b0) $display("FAIL tmo_req got %0h want 0", dmem_req); else passed++;
    step();
    total++; if (w_valid !== 1'b0) $display("FAIL tmo_pulse got %0h want 0", w_valid); else passed++;
  endtask

  task automatic test_misalign();
    clr(); m_valid = 1; memwriteM = 1; regwriteM = 1; funct3M = 3'b010; aluresultM = 32'h3001;
    Rd2M = 32'h55; dmem_gnt = 1;
    #1;
`ifdef MISALIGN_TRAP_EN
    total++; if (dmem_req !== 1'b0) $display("FAIL mis_req got %0h want 0", dmem_req); else passed++;
    step(); clr();
    total++; if ({w_valid, misalignW, regwriteW} !== 3'b110) $display("FAIL mis_retire got %b want 110", {w_valid, misalignW, regwriteW}); else passed++;
`else
    total++; if ({dmem_req, dmem_addr, dmem_be} !== {1'b1, 32'h3000, 4'b1111}) $display("FAIL sw_odd_req got %h want %h", {dmem_req, dmem_addr, dmem_be}, {1'b1, 32'h3000, 4'b1111}); else passed++;
    step(); clr();
    total++; if ({w_valid, misalignW} !== 2'b10) $display("FAIL sw_odd_retire got %b want 10", {w_valid, misalignW}); else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    clr(); m_valid = 1; aluresultM = 32'hA; RdM = 1;
    step();
    aluresultM = 32'hB; RdM = 2;
    total++; if ({w_valid, RdW} !== {1'b1, 5'd1}) $display("FAIL b2b_first got %h want 21", {w_valid, RdW}); else passed++;
    step(); clr();
    total++; if ({w_valid, RdW, aluresultW} !== {1'b1, 5'd2, 32'hB}) $display("FAIL b2b_second got %h want %h", {w_valid, RdW, aluresultW}, {1'b1, 5'd2, 32'hB}); else passed++;
  endtask

  task automatic test_reset_mid_load();
    clr(); m_valid = 1; memreadM = 1; regwriteM = 1; funct3M = 3'b010; aluresultM = 32'h40;
    RdM = 4; dmem_gnt = 1;
    step(); clr();
    dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
    #2 rst_n = 0;
    #1;
    total++; if ({m_ready, dmem_req, w_valid} !== 3'b100) $display("FAIL rst_mid_ctl got %b want 100", {m_ready, dmem_req, w_valid}); else passed++;
    total++; if ({RdW, ReadDataW, aluresultW} !== 69'h0) $display("FAIL rst_mid_w got %h want 0", {RdW, ReadDataW, aluresultW}); else passed++;
    step();
    @(negedge clk) rst_n = 1;
    step(); dmem_rvalid = 0;
    total++; if ({w_valid, ReadDataW, m_ready} !== {1'b0, 32'h0, 1'b1}) $display("FAIL rst_late_rvalid got %h want 1", {w_valid, ReadDataW, m_ready}); else passed++;
  endtask

  initial begin
    rst_n = 0;
    clr();
    test_reset();
    test_store_byte();
    test_load_ext();
    test_load_wait();
    test_store_half_wait();
    test_non_mem();
    test_flush_resp();
    test_timeout();
    test_misalign();
    test_back_to_back();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
